// File: rtl/multi_cycle_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One multiplier or quotient bit per cycle; signs handled around the unsigned core.
module multi_cycle_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_in1;
   logic [WIDTH-1:0]   r_in2;
   logic               r_res_neg;
   logic               r_dvd_neg;
   logic               r_dbz;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_dvs;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_dbz_out;

   logic               w_signed;
   logic               w_is_div;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_calc_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic en);
      return (en && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] f_cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   assign w_signed = ~r_op[0];
   assign w_is_div = r_op[1];

   // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each cycle.
   assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_dvs & {WIDTH{r_acc[0]}})};

   // Divide: r_acc = {remainder, dividend/quotient}, shifted left each cycle.
   assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_dvs};

   always_comb begin
      w_calc_next = {w_sum, r_acc[WIDTH-1:1]};
      if (w_is_div) begin
         if (w_trial[WIDTH])
            w_calc_next = {r_acc[2*WIDTH-2:0], 1'b0};
         else
            w_calc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end
   end

   assign w_prod = f_cond_neg2(r_acc, r_res_neg);

   always_comb begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (r_dbz) begin
         w_fix_hi = r_in1;
         w_fix_lo = '1;
      end else if (w_is_div) begin
         w_fix_hi = f_cond_neg(r_acc[2*WIDTH-1:WIDTH], r_dvd_neg);
         w_fix_lo = f_cond_neg(r_acc[WIDTH-1:0], r_res_neg);
      end
   end

   // Control state and architectural HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_PREP;
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            S_PREP: begin
               r_cnt   <= '0;
               r_state <= (w_is_div && (r_in2 == '0)) ? S_FIX : S_CALC;
            end
            S_CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_ITER) r_state <= S_FIX;
            end
            default: begin
               r_hi      <= w_fix_hi;
               r_lo      <= w_fix_lo;
               r_done    <= 1'b1;
               r_dbz_out <= r_dbz;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   // Operand capture, sign preparation and iteration datapath
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: begin
            if (start) begin
               r_op  <= op;
               r_in1 <= in1;
               r_in2 <= in2;
            end
         end
         S_PREP: begin
            r_acc     <= {{WIDTH{1'b0}}, f_abs(r_in1, w_signed)};
            r_dvs     <= f_abs(r_in2, w_signed);
            r_res_neg <= w_signed & (r_in1[WIDTH-1] ^ r_in2[WIDTH-1]);
            r_dvd_neg <= w_signed & r_in1[WIDTH-1];
            r_dbz     <= w_is_div & (r_in2 == '0);
         end
         S_CALC: begin
            r_acc <= w_calc_next;
         end
         default: ;
      endcase
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dbz_out;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_multi_cycle_mdu.sv
// Bench for multi_cycle_mdu at WIDTH = 32: transaction-level reference model
// checked every cycle, plus directed operations with hand-computed results.
module tb_multi_cycle_mdu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  in1, in2, wdata;
   logic          hi_we, lo_we;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   multi_cycle_mdu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: what HI/LO must hold after an operation.
   function automatic void model_calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      z = 1'b0;
      h = '0;
      l = '0;
      case (o)
         2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
         default: begin
            if (b == '0) begin
               h = a; l = '1; z = 1'b1;
            end else if (o == 2'b10) begin
               q = sa / sb; r = sa % sb;
               l = q[31:0]; h = r[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   // Transaction model: idle/busy with a countdown of remaining edges.
   logic         m_init = 1'b0;
   logic         m_busy, m_done, m_dbz, p_dbz;
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   int           m_left;

   always @(posedge clk) begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (reset) begin
         m_init = 1'b1;
         m_busy = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
      end else if (m_init) begin
         if (!m_busy) begin
            if (start) begin
               model_calc(op, in1, in2, p_hi, p_lo, p_dbz);
               m_left = p_dbz ? 2 : W + 2;
               m_busy = 1'b1;
            end else begin
               if (hi_we) m_hi = wdata;
               if (lo_we) m_lo = wdata;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_done = 1'b1;
               m_dbz  = p_dbz;
               m_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
         check("hi", 64'(hi), 64'(m_hi));
         check("lo", 64'(lo), 64'(m_lo));
         if (busy && done) check("busy_and_done", 64'(1), 64'(0));
      end
   end

   task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez, input int elat);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; in1 = a; in2 = b;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      in1 = $urandom; in2 = $urandom; op = 2'($urandom);
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         check({nm, "_timeout"}, 64'(lat), 64'(elat));
      end else begin
         check({nm, "_latency"}, 64'(lat), 64'(elat));
         check({nm, "_hi"}, 64'(hi), 64'(eh));
         check({nm, "_lo"}, 64'(lo), 64'(el));
         check({nm, "_dbz"}, 64'(div_by_zero), 64'(ez));
      end
   endtask

   initial begin
      int cyc;
      int seen_done;
      reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);

      do_op("mult_neg1x2", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
      do_op("multu",       2'b01, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34);
      do_op("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      do_op("divu_by0",    2'b11, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF, 1'b1, 2);
      do_op("div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
      do_op("mult_m3_m5",  2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF, 1'b0, 34);
      do_op("divu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
      do_op("div_7_m2",    2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34);
      do_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34);
      do_op("div_by0",     2'b10, 32'h80000000, 32'h0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 2);

      @(negedge clk);
      hi_we = 1'b1; wdata = 32'hA5A50001;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi", 64'(hi), 64'hA5A50001);
      lo_we = 1'b1; wdata = 32'h5A5A0002;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo", 64'(lo), 64'h5A5A0002);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mthi_both", 64'(hi), 64'h12345678);
      check("mtlo_both", 64'(lo), 64'h12345678);

      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      do_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);

      @(negedge clk);
      start = 1'b1; op = 2'b00; in1 = 32'd3; in2 = 32'd5;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      seen_done = 0;
      while (cyc < 20) begin
         if (cyc == 10) begin
            start = 1'b1; hi_we = 1'b1; wdata = 32'hCAFEF00D;
            in1 = 32'd9; in2 = 32'd9; op = 2'b01;
         end else begin
            start = 1'b0; hi_we = 1'b0;
         end
         if (done) seen_done = 1;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; hi_we = 1'b0;
      check("abort_busy_before", 64'(busy), 64'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_hi", 64'(hi), 64'h0);
      check("abort_lo", 64'(lo), 64'h0);
      repeat (50) begin
         if (done) seen_done = 1;
         @(negedge clk);
      end
      check("abort_no_done", 64'(seen_done), 64'h0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_mdu.md
MULTI_CYCLE_MDU -- requirements
Module: multi_cycle_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 8 to 64, even only.
REQ-002 The block SHALL have the following ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high; sampled on the rising clk edge.
- start  in  1  Operation request; sampled only in IDLE.
- op  in  2  Operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- in1  in  WIDTH  Multiplicand or dividend.
- in2  in  WIDTH  Multiplier or divisor.
- hi_we  in  1  Write HI from wdata (mthi).
- lo_we  in  1  Write LO from wdata (mtlo).
- wdata  in  WIDTH  Data for HI/LO writes.
- busy  out  1  High in states PREP, CALC and FIX.
- done  out  1  One-cycle pulse when a result is written to HI/LO.
- div_by_zero  out  1  Qualified by done; high when a div/divu had in2 == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Function
REQ-003 The FSM SHALL have the states IDLE, PREP, CALC and FIX, with these transitions:
- IDLE -> PREP when start is high.
- PREP -> CALC, or PREP -> FIX when the operation is a division and the divisor is 0.
- CALC -> FIX after exactly WIDTH iteration cycles.
- FIX -> IDLE.
REQ-004 In IDLE with start high, the block SHALL latch op, in1 and in2 on that edge; later changes to these inputs SHALL NOT affect the result.
REQ-005 In PREP, signed operations SHALL take the absolute values of both operands and record the result sign and the dividend sign; unsigned operations SHALL use the operands as-is.
REQ-006 In CALC, multiplication SHALL be unsigned shift-add, one multiplier bit per cycle, producing a 2*WIDTH-bit product.
REQ-007 In CALC, division SHALL be restoring division, one quotient bit per cycle, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
REQ-008 In FIX, the block SHALL apply sign correction and then write HI/LO on the exiting edge:
- Multiplication: {HI, LO} = product, negated as 2*WIDTH bits if the result sign is negative.
- Division: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-009 Signed division of the most negative value by -1 SHALL yield LO = the most negative value and HI = 0.
REQ-010 Division by zero SHALL give LO = all ones and HI = in1 (unmodified), with div_by_zero = 1 during the done cycle.
REQ-011 Latency, counting start sampled at edge 0:
- Normal operations: done high for the one cycle following edge WIDTH+2, with HI/LO updated on edge WIDTH+2.
- Division by zero: done and HI/LO update at edge 2.
REQ-012 busy SHALL be high from the cycle after start is sampled until the edge at which done rises; busy and done SHALL never both be high.
REQ-013 start asserted while busy SHALL be ignored, with no queuing.
REQ-014 hi_we and lo_we SHALL take effect only in IDLE, writing on the next edge; while busy they SHALL be ignored.
REQ-015 In IDLE, if start is high together with hi_we or lo_we, start SHALL win and the write SHALL be dropped.
REQ-016 If hi_we and lo_we are both high in IDLE, both registers SHALL be written from wdata.
REQ-017 div_by_zero SHALL be 0 whenever done is 0.
REQ-018 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-019 On reset high at a clock edge, regardless of state, the block SHALL enter IDLE and set hi = 0, lo = 0, busy = 0, done = 0 and div_by_zero = 0.
REQ-020 Reset in mid-operation SHALL abort the operation with no HI/LO write.
REQ-021 Reset SHALL take precedence over start, hi_we and lo_we.

Verification (WIDTH = 32)
REQ-022 mult, in1 = 0xFFFFFFFF, in2 = 0x00000002 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done exactly 34 cycles after start.
REQ-023 multu, same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-024 div, in1 = 0xFFFFFFF9 (-7), in2 = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_by_zero = 0.
REQ-025 divu, in1 = 7, in2 = 0 -> done 2 cycles after start, div_by_zero = 1, lo = 0xFFFFFFFF, hi = 0x00000007.
REQ-026 div, in1 = 0x80000000, in2 = 0xFFFFFFFF -> lo = 0x80000000, hi = 0x00000000.
REQ-027 Start a mult; at cycle 10 pulse start with new operands and hi_we = 1; at cycle 20 assert reset -> the second start and the hi write are ignored, reset gives busy = 0, hi = lo = 0, and done never pulses.
